usb_tx_sequencer: RTL and testbench

Transmit-side controller that sequences the NRZI encoder stage of the USB transceiver. It accepts packet bytes over a valid/ready handshake and emits one raw bit per clock: SYNC, LSB-first data with bit stuffing, then EOP. It drives the encoder's enable and bit inputs, plus a separate SE0 request for the line driver. It sits between the packet/CRC layer and the NRZI encoder.

---
 rtl/usb_tx_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: serialises packet bytes into the raw (pre-NRZI) USB bit
// stream. Each frame is SYNC, LSB-first data with bit stuffing, then EOP.
// Each clock emits one bit. All outputs except tx_ready are registered.
module usb_tx_sequencer (
  input  logic       clk,
  input  logic       nRST,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       enc_en,
  output logic       enc_bit,
  output logic       se0,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_DATA    = 3'd2,
    S_STUFF   = 3'd3,
    S_EOP_SE0 = 3'd4,
    S_EOP_J   = 3'd5
  } state_t;

  // state_q describes the bit currently on the outputs.
  // In DATA/STUFF, bit_cnt_q is the index of the last data bit emitted.
  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       eop_cnt_q, eop_cnt_d;
  logic       last_q, last_d;      // no further byte: EOP follows the pending stuff bit
  logic       enc_en_q, enc_en_d;
  logic       enc_bit_q, enc_bit_d;
  logic       se0_q, se0_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx_done_q, tx_done_d;

  logic       accept;
  logic [2:0] nxt_idx;

  // A byte is taken in IDLE, or while the last bit of the current byte is on the line.
  assign tx_ready = (state_q == S_IDLE) || ((state_q == S_DATA) && (bit_cnt_q == 3'd7));
  assign accept   = tx_valid && tx_ready;
  assign nxt_idx  = bit_cnt_q + 3'd1;  // wraps 7 -> 0 when a new byte starts

  assign enc_en  = enc_en_q;
  assign enc_bit = enc_bit_q;
  assign se0     = se0_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  // Next-state and next-output decode: decide which bit is emitted on the coming cycle.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    eop_cnt_d  = eop_cnt_q;
    last_d     = last_q;
    enc_en_d   = 1'b0;
    enc_bit_d  = 1'b0;
    se0_d      = 1'b0;
    tx_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d    = tx_data;
          sync_cnt_d = 3'd0;
          last_d     = 1'b0;
          state_d    = S_SYNC;
          enc_en_d   = 1'b1;
          enc_bit_d  = 1'b0;
        end
      end

      S_SYNC: begin
        enc_en_d = 1'b1;
        if (sync_cnt_q != 3'd7) begin
          sync_cnt_d = sync_cnt_q + 3'd1;
          enc_bit_d  = (sync_cnt_q == 3'd6);  // SYNC ends with a single 1
        end else begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          enc_bit_d = shreg_q[0];
        end
      end

      S_DATA: begin
        if (bit_cnt_q == 3'd7) begin
          if (accept) begin
            shreg_d = tx_data;
          end else begin
            last_d = 1'b1;
          end
        end
        if (ones_cnt_q == 3'd6) begin
          // Six 1s in a row were just sent: insert a 0 and hold the bit index.
          state_d   = S_STUFF;
          enc_en_d  = 1'b1;
          enc_bit_d = 1'b0;
        end else if ((bit_cnt_q != 3'd7) || accept) begin
          bit_cnt_d = nxt_idx;
          enc_en_d  = 1'b1;
          enc_bit_d = shreg_d[nxt_idx];
        end else begin
          state_d   = S_EOP_SE0;
          eop_cnt_d = 1'b0;
          se0_d     = 1'b1;
        end
      end

      S_STUFF: begin
        if (last_q) begin
          state_d   = S_EOP_SE0;
          eop_cnt_d = 1'b0;
          se0_d     = 1'b1;
        end else begin
          state_d   = S_DATA;
          bit_cnt_d = nxt_idx;
          enc_en_d  = 1'b1;
          enc_bit_d = shreg_q[nxt_idx];
        end
      end

      S_EOP_SE0: begin
        if (!eop_cnt_q) begin
          eop_cnt_d = 1'b1;
          se0_d     = 1'b1;
        end else begin
          state_d   = S_EOP_J;
          tx_done_d = 1'b1;
        end
      end

      S_EOP_J: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Run length of 1s on the line; a 0 (data, SYNC or stuff) restarts it, and it
    // never climbs past 6 because reaching 6 always forces a stuff bit next.
    if (enc_en_d) begin
      if (enc_bit_d) begin
        ones_cnt_d = (ones_cnt_q == 3'd6) ? 3'd6 : ones_cnt_q + 3'd1;
      end else begin
        ones_cnt_d = 3'd0;
      end
    end else begin
      ones_cnt_d = 3'd0;
    end

    tx_busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame with no EOP.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      sync_cnt_q <= 3'd0;
      ones_cnt_q <= 3'd0;
      eop_cnt_q  <= 1'b0;
      last_q     <= 1'b0;
      enc_en_q   <= 1'b0;
      enc_bit_q  <= 1'b0;
      se0_q      <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      eop_cnt_q  <= eop_cnt_d;
      last_q     <= last_d;
      enc_en_q   <= enc_en_d;
      enc_bit_q  <= enc_bit_d;
      se0_q      <= se0_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Testbench for usb_tx_sequencer: table of hand-computed frames, directed
// reset sequences, and random frames checked cycle by cycle against a bit-stream model.
module tb_usb_tx_sequencer;

  logic       clk;
  logic       nRST;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       enc_en;
  logic       enc_bit;
  logic       se0;
  logic       tx_busy;
  logic       tx_done;

  usb_tx_sequencer dut (
    .clk      (clk),
    .nRST     (nRST),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .enc_en   (enc_en),
    .enc_bit  (enc_bit),
    .se0      (se0),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle; nxt marks a cycle where the bench offers the next byte.
  typedef struct packed {
    logic ready;
    logic en;
    logic b;
    logic se0;
    logic busy;
    logic done;
    logic nxt;
  } ent_t;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         stuffs;
    int         busy_len;
  } vec_t;

  int         n_assert;
  int         n_fail;
  logic [7:0] frame_q[$];
  ent_t       exp_q[$];
  int         model_stuffs;
  int         en_seen;
  int         busy_seen;
  logic       hold_valid;
  logic [5:0] outs;

  assign outs = {tx_ready, enc_en, enc_bit, se0, tx_busy, tx_done};

  function automatic ent_t mk(logic r, logic e, logic b, logic s, logic bz, logic d, logic nx);
    ent_t t;
    t.ready = r; t.en = e; t.b = b; t.se0 = s; t.busy = bz; t.done = d; t.nxt = nx;
    return t;
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got {rdy,en,bit,se0,busy,done}=%b expected %b", name, $time, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    n_assert++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference stream: SYNC, LSB-first data with a 0 after every run of six 1s
  // (the SYNC 1 counts), then two SE0 cycles, one J cycle, back to idle.
  task automatic build_frame();
    int ones;
    int n;
    logic bv;
    ones = 0;
    n = frame_q.size();
    model_stuffs = 0;
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(0, 1, (i == 7), 0, 1, 0, 0));
    end
    ones = 1;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < 8; i++) begin
        bv = frame_q[j][i];
        exp_q.push_back(mk((i == 7), 1, bv, 0, 1, 0, (i == 7) && (j < n - 1)));
        ones = bv ? ones + 1 : 0;
        if (ones == 6) begin
          exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0));
          ones = 0;
          model_stuffs++;
        end
      end
    end
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
  endtask

  // Step through the expected stream: check at each falling edge, then drive inputs.
  task automatic play(input int limit);
    int k;
    ent_t e;
    k = 0;
    en_seen = 0;
    busy_seen = 0;
    for (int idx = 0; idx < exp_q.size() && idx < limit; idx++) begin
      @(negedge clk);
      e = exp_q[idx];
      chk("cycle", outs, {e.ready, e.en, e.b, e.se0, e.busy, e.done});
      if (enc_en) en_seen++;
      if (tx_busy) busy_seen++;
      if (e.nxt) begin
        tx_valid = 1'b1;
        tx_data  = frame_q[k];
        k++;
      end else if (e.ready) begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  int   nb;

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    hold_valid = 1'b1;
    tbl[0] = '{1, 8'h00, 8'h00, 8'h00, 0, 19};
    tbl[1] = '{1, 8'hFF, 8'h00, 8'h00, 1, 20};
    tbl[2] = '{2, 8'hFF, 8'hFF, 8'h00, 2, 29};
    tbl[3] = '{1, 8'hFC, 8'h00, 8'h00, 1, 20};
    tbl[4] = '{3, 8'h7E, 8'h3F, 8'h80, 2, 37};
    tbl[5] = '{2, 8'hA5, 8'h01, 8'h00, 0, 27};

    // Reset with no stimulus: ready high, everything else low.
    nRST     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("reset_held", outs, 6'b100000);
    end
    nRST = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_after_reset", outs, 6'b100000);
    end

    // Table frames, with tx_valid held high on every non-ready cycle.
    for (int t = 0; t < 6; t++) begin
      frame_q.delete();
      frame_q.push_back(tbl[t].b0);
      if (tbl[t].n > 1) frame_q.push_back(tbl[t].b1);
      if (tbl[t].n > 2) frame_q.push_back(tbl[t].b2);
      build_frame();
      play(exp_q.size());
      chk_int("enc_en_len", en_seen, 8 + 8 * tbl[t].n + tbl[t].stuffs);
      chk_int("busy_len", busy_seen, tbl[t].busy_len);
      $display("table frame %0d: %0d byte(s), enc_en %0d cycles, busy %0d cycles",
               t, tbl[t].n, en_seen, busy_seen);
    end

    // Reset in the middle of DATA: immediate return to reset values, no EOP.
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h5A);
    build_frame();
    play(14);
    #2;
    tx_valid = 1'b0;
    nRST     = 1'b0;
    #1;
    chk("async_reset", outs, 6'b100000);
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_eop", outs, 6'b100000);
    end
    nRST = 1'b1;
    frame_q.delete();
    frame_q.push_back(8'hFF);
    build_frame();
    play(exp_q.size());
    chk_int("post_reset_en_len", en_seen, 17);
    $display("reset mid-frame then clean frame 0xFF: enc_en %0d cycles", en_seen);

    // Random frames, biased toward 0xFF runs to exercise stuffing.
    for (int f = 0; f < 30; f++) begin
      hold_valid = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      frame_q.delete();
      for (int j = 0; j < nb; j++) begin
        frame_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      end
      build_frame();
      play(exp_q.size());
      chk_int("rand_en_len", en_seen, 8 + 8 * nb + model_stuffs);
      $display("random frame %0d: %0d byte(s), %0d stuff bit(s)", f, nb, model_stuffs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
